iterative_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 17 +
 rtl/iterative_shifter_shift_step.sv | 30 +++
 rtl/iterative_shifter.sv | 128 ++++++++++++
 tb/tb_iterative_shifter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: operation encodings and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_ROTR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shifter_state_t;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single-step shifter used once per iteration by iterative_shifter.
// Rotate support is present only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  shift_op_t        op,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      SHIFT_SLL: shifted = value << k;
      // Right shifts pull fill bits in from a doubled-width word.
      SHIFT_SRL, SHIFT_SRA: shifted = WIDTH'({{WIDTH{fill}}, value} >> k);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      SHIFT_ROTR: shifted = WIDTH'({value, value} >> k);
`endif
      default: shifted = value << k;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: shifts up to STEP bits per clock between two valid/ready handshakes.
// Optional rotate-right on op 11 via ITERATIVE_SHIFTER_ROTATE_EN (otherwise op 11 acts as SLL).
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               busy
);

  localparam int KW = $clog2(STEP + 1);

  shifter_state_t     state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [SHAMT_W-1:0] remaining_reg, remaining_next;
  shift_op_t          op_reg, op_next;
  logic               sign_reg, sign_next;

  shift_op_t          op_dec;
  logic [SHAMT_W-1:0] eff;
  logic [KW-1:0]      k;
  logic               fill;
  logic [WIDTH-1:0]   step_value;

  // Decode the incoming op and its effective amount at the accept edge only.
  always_comb begin
    op_dec = shift_op_t'(op);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    if (op_dec == SHIFT_ROTR) begin
      eff = shamt % SHAMT_W'(WIDTH);
    end else begin
      eff = (shamt >= SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt;
    end
`else
    if (op_dec == SHIFT_ROTR) begin
      op_dec = SHIFT_SLL;
    end
    eff = (shamt >= SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt;
`endif
  end

  always_comb begin
    if (remaining_reg < SHAMT_W'(STEP)) begin
      k = KW'(remaining_reg);
    end else begin
      k = KW'(STEP);
    end
    fill = (op_reg == SHIFT_SRA) ? sign_reg : 1'b0;
  end

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .value  (result_reg),
    .k      (k),
    .op     (op_reg),
    .fill   (fill),
    .shifted(step_value)
  );

  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    remaining_next = remaining_reg;
    op_next        = op_reg;
    sign_next      = sign_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          result_next    = data_in;
          op_next        = op_dec;
          sign_next      = data_in[WIDTH-1];
          remaining_next = eff;
          state_next     = (eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_next    = step_value;
        remaining_next = remaining_reg - SHAMT_W'(k);
        if (remaining_reg == SHAMT_W'(k)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      remaining_reg <= '0;
      op_reg        <= SHIFT_SLL;
      sign_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      remaining_reg <= remaining_next;
      op_reg        <= op_next;
      sign_reg      <= sign_next;
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign done_valid  = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign result      = result_reg;

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (WIDTH=32, STEP=4) against an arithmetic reference model.
module tb_iterative_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 6;
  localparam int STEP    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_valid;
  logic               start_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result;
  logic               done_valid;
  logic               done_ready;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W),
    .STEP   (STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op         (op),
    .data_in    (data_in),
    .shamt      (shamt),
    .result     (result),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy       (busy)
  );

  function automatic int model_eff(input logic [1:0] o, input int s);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    if (o == 2'b11) return s % WIDTH;
`endif
    return (s > WIDTH) ? WIDTH : s;
  endfunction

  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] d, input int s);
    int r;
    logic [1:0] oo;
    oo = o;
`ifndef ITERATIVE_SHIFTER_ROTATE_EN
    if (oo == 2'b11) oo = 2'b00;
`endif
    case (oo)
      2'b00: return (s >= 32) ? 32'h0 : (d << s);
      2'b01: return (s >= 32) ? 32'h0 : (d >> s);
      2'b10: return (s >= 32) ? {32{d[31]}} : 32'($signed(d) >>> s);
      default: begin
        r = s % 32;
        if (r == 0) return d;
        return (d >> r) | (d << (32 - r));
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [5:0] s,
                        input int hold, input bit pulse);
    logic [31:0] exp_res;
    int exp_cyc;
    int cyc;
    exp_res = model_result(o, d, int'(s));
    exp_cyc = (model_eff(o, int'(s)) + STEP - 1) / STEP;
    cyc = 0;
    while (start_ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_idle: got %b want 1", start_ready);
    end
    op = o; data_in = d; shamt = s; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op = 2'($urandom); data_in = $urandom; shamt = 6'($urandom);
    cyc = 0;
    while (done_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL latency op=%0d shamt=%0d: got %0d cycles want %0d", o, s, cyc, exp_cyc);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL result op=%0d data=%h shamt=%0d: got %h want %h", o, d, s, result, exp_res);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        start_valid = 1'b1; data_in = ~d; shamt = 6'd1; op = 2'b01;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      checks++;
      if (done_valid !== 1'b1 || result !== exp_res || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: got done_valid=%b result=%h start_ready=%b want 1 %h 0",
                 i, done_valid, result, start_ready, exp_res);
      end
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: got busy=%b start_ready=%b done_valid=%b want 0 1 0",
               busy, start_ready, done_valid);
    end
    $display("op=%0d data=%h shamt=%0d result=%h expected=%h cycles=%0d", o, d, s, result, exp_res, exp_cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    op = 2'b00; data_in = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || done_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got start_ready=%b done_valid=%b busy=%b result=%h want 1 0 0 0",
               start_ready, done_valid, busy, result);
    end
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'd10, 6'd2, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 6'd31, 0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 6'd31, 0, 1'b0);
    run_op(2'b00, 32'd100, 6'd0, 0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 6'd40, 0, 1'b0);
    run_op(2'b10, 32'h8765_4321, 6'd63, 0, 1'b0);
    run_op(2'b00, 32'h0000_0001, 6'd32, 0, 1'b0);
    run_op(2'b11, 32'h1234_5678, 6'd36, 0, 1'b0);
    run_op(2'b11, 32'h1234_5678, 6'd32, 0, 1'b0);
    run_op(2'b10, 32'h4000_0000, 6'd5, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [5:0] s;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: s = 6'($urandom_range(0, 4));
        1: s = 6'($urandom_range(30, 33));
        default: s = 6'($urandom);
      endcase
      run_op(2'($urandom), $urandom, s, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_backpressure();
    run_op(2'b10, 32'hF00D_BEEF, 6'd9, 5, 1'b1);
    run_op(2'b00, 32'h0000_00FF, 6'd0, 5, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    start_valid = 1'b1; op = 2'b01; data_in = $urandom | 32'h1; shamt = 6'd40;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done_valid !== 1'b0 || result !== 32'h0 || start_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got done_valid=%b result=%h start_ready=%b busy=%b want 0 0 1 0",
               done_valid, result, start_ready, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dropped_op cycle %0d: got done_valid=%b busy=%b want 0 0", i, done_valid, busy);
      end
    end
    $display("reset mid-shift: result=%h start_ready=%b", result, start_ready);
  endtask

  task automatic test_back_to_back();
    int idx[$];
    int cyc;
    int period;
    logic [31:0] d;
    d = $urandom;
    period = (8 + STEP - 1) / STEP + 2;
    op = 2'b01; data_in = d; shamt = 6'd8;
    start_valid = 1'b1; done_ready = 1'b1;
    cyc = 0;
    while (idx.size() < 4 && cyc < 60) begin
      if (start_ready === 1'b1) idx.push_back(cyc);
      if (done_valid === 1'b1) begin
        checks++;
        if (result !== (d >> 8)) begin
          errors++;
          $display("FAIL b2b_result: got %h want %h", result, d >> 8);
        end
      end
      @(posedge clk); #1; cyc++;
    end
    start_valid = 1'b0; done_ready = 1'b0;
    checks++;
    if (idx.size() != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts want 4", idx.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (idx[i] - idx[i-1] != period) begin
          errors++;
          $display("FAIL b2b_period: got %0d cycles want %0d", idx[i] - idx[i-1], period);
        end
      end
    end
    done_ready = 1'b1;
    repeat (period + 2) @(posedge clk);
    #1 done_ready = 1'b0;
    $display("back-to-back: data=%h accepts=%0d period=%0d", d, idx.size(), period);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
